ublock_inv_sbox_serial: RTL
===========================

# ublock_inv_sbox_serial

- Nibble-serial uBlock inverse S-box layer for the decryption datapath.
- Undoes the forward S-box layer that the encryption rounds build from NAND-XOR cells.
- Accepts a full state word over a valid/ready handshake, substitutes `LANES` nibbles per cycle in place, and returns the word over a second valid/ready handshake.
- Sits between the round-key XOR and the inverse linear layer in the decryption round.

## Interface
Parameters:
- `WIDTH`, 128: state width in bits. Must be a multiple of 4·`LANES`.
- `LANES`, 4: nibbles substituted per cycle. Legal values: 1, 2, 4, 8, 16, 32.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: reset; synchronous and active-high.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: block can accept a word.
- `in_data`, input, `WIDTH`: ciphertext-side state word.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: downstream accepts `out_data`.
- `out_data`, output, `WIDTH`: substituted state word.
- `mode`, input, 1: present only with `UBLOCK_SBOX_FWD_EN`; see Configuration.

## Operation
- Inverse S-box, normative, indexed by input nibble 0..F: C,A,E,D,1,F,B,0,7,2,5,4,3,6,9,8.
- Forward S-box, used only in forward mode: 7,4,9,C,B,A,D,8,F,E,1,6,0,3,2,5.
- An implementation as the forward NAND-XOR chain applied in reverse order is permitted if it matches the table exactly.
- Nibble i occupies bits [4i+3:4i]. Every nibble is substituted independently; no mixing between nibbles.
- `N` = `WIDTH`/(4·`LANES`) beats. Beat counter `cnt` is `$clog2(N)` bits wide (minimum 1).
- FSM states and transitions:
  - IDLE: `in_ready`=1. When `in_valid`=1, load `in_data` into the state register, set `cnt`=0, go to RUN.
  - RUN: each cycle, replace nibbles `cnt`·`LANES` .. `cnt`·`LANES`+`LANES`-1 with their substituted value. The least-significant group goes first. When `cnt`=N-1, go to DONE; otherwise increment `cnt`.
  - DONE: `out_valid`=1 and `out_data` = state register, held stable. When `out_ready`=1, go to IDLE.
- `in_ready` is high only in IDLE; there is no overlap between words.
- Inputs are ignored outside IDLE: `in_valid` high during RUN or DONE has no effect.
- `out_ready` is ignored outside DONE.
- `out_data` is the state register in every state. Its contents are defined only while `out_valid`=1.

## Timing
- Reset: `rst` high at a rising edge forces IDLE, `cnt`=0, and clears the state register to 0. This holds in any state, including mid-RUN and DONE.
- After reset, outputs are `in_ready`=1, `out_valid`=0, `out_data`=0. Any partially processed word is discarded.
- Latency: with the input handshake on edge T, `out_valid` rises after edge T+N. For the defaults (N=8), that is 8 cycles.
- The output handshake on edge T+N+k returns the block to IDLE, with `in_ready`=1 from edge T+N+k+1 onward.
- Best-case throughput: one word per N+2 cycles.
- `in_ready` and `out_valid` are registered-state decodes only; there is no combinational path from `in_valid` or `out_ready`.

## Configuration
- Macro: `UBLOCK_SBOX_FWD_EN`.
- Defined:
  - `mode` port exists and is sampled at the input handshake.
  - 0 selects the inverse table; 1 selects the forward table.
  - The sampled value is held for the whole word. Reset clears it to 0.
- Undefined:
  - `mode` port is absent and the block is inverse-only.
  - Logic and timing are otherwise identical.

## Test plan
All scenarios use the defaults (`WIDTH`=128, `LANES`=4) unless stated.
- All-zero input: `in_data`=0 → `out_data`=0xCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC. `out_valid` rises exactly 8 cycles after acceptance.
- Full table: `in_data`=0x0123456789ABCDEF0123456789ABCDEF → `out_data`=0xCAED1FB072543698CAED1FB072543698. Also feed that output through the forward mode (macro defined) and check the original word is recovered.
- Backpressure: hold `out_ready`=0 for 20 cycles in DONE → `out_data` stable, `in_ready`=0, and a new `in_valid` word is not accepted. On `out_ready`=1 the block returns to IDLE one cycle later.
- Reset mid-RUN: assert `rst` for one cycle at `cnt`=3 → next cycle shows `in_ready`=1, `out_valid`=0, `out_data`=0. A following all-F word yields 0x8888…8.
- Parameter sweep: `LANES`=1 (N=32) and `LANES`=32 (N=1) with random words → results match a table model, with latency N.
- Forward mode (macro defined, `mode`=1): all-zero input → 0x7777…7. Toggling `mode` during RUN does not change the result.

Source files
------------

// File: rtl/ublock_inv_sbox_serial.sv
// Nibble-serial uBlock inverse S-box layer, LANES nibbles per beat.
// Define UBLOCK_SBOX_FWD_EN to add a mode port selecting the forward table.
module ublock_inv_sbox_serial #(
  parameter int WIDTH = 128,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef UBLOCK_SBOX_FWD_EN
  ,
  input  logic             mode
`endif
);

  localparam int N  = WIDTH / (4 * LANES);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] st;
  logic [WIDTH-1:0] nxt;

  function automatic logic [3:0] inv_sb(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'hA;
      4'h2: y = 4'hE;
      4'h3: y = 4'hD;
      4'h4: y = 4'h1;
      4'h5: y = 4'hF;
      4'h6: y = 4'hB;
      4'h7: y = 4'h0;
      4'h8: y = 4'h7;
      4'h9: y = 4'h2;
      4'hA: y = 4'h5;
      4'hB: y = 4'h4;
      4'hC: y = 4'h3;
      4'hD: y = 4'h6;
      4'hE: y = 4'h9;
      default: y = 4'h8;
    endcase
    return y;
  endfunction

`ifdef UBLOCK_SBOX_FWD_EN
  logic fwd;

  function automatic logic [3:0] fwd_sb(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'h7;
      4'h1: y = 4'h4;
      4'h2: y = 4'h9;
      4'h3: y = 4'hC;
      4'h4: y = 4'hB;
      4'h5: y = 4'hA;
      4'h6: y = 4'hD;
      4'h7: y = 4'h8;
      4'h8: y = 4'hF;
      4'h9: y = 4'hE;
      4'hA: y = 4'h1;
      4'hB: y = 4'h6;
      4'hC: y = 4'h0;
      4'hD: y = 4'h3;
      4'hE: y = 4'h2;
      default: y = 4'h5;
    endcase
    return y;
  endfunction
`endif

  // Only the group selected by cnt changes; the rest passes through.
  always_comb begin
    nxt = st;
    for (int l = 0; l < LANES; l++) begin
`ifdef UBLOCK_SBOX_FWD_EN
      nxt[(int'(cnt) * LANES + l) * 4 +: 4] = fwd ?
        fwd_sb(st[(int'(cnt) * LANES + l) * 4 +: 4]) :
        inv_sb(st[(int'(cnt) * LANES + l) * 4 +: 4]);
`else
      nxt[(int'(cnt) * LANES + l) * 4 +: 4] =
        inv_sb(st[(int'(cnt) * LANES + l) * 4 +: 4]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      st        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef UBLOCK_SBOX_FWD_EN
      fwd       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st       <= in_data;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
`ifdef UBLOCK_SBOX_FWD_EN
            fwd      <= mode;
`endif
          end
        end
        RUN: begin
          st <= nxt;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = st;

endmodule
